// File: rtl/exception_controller.sv
// Trap sequencer: sticky pending events, fixed priority (bit5 highest), stall/drain/flush, vector handshake, trap mode until return.
// Latency event->stall 1, flush 2, vector_valid 3, trap_mode 4 cycles; vector held until vector_ack. Optional mask: EXCEPTION_MASK_EN.
module exception_controller #(
  parameter int                       ADDRESS_WIDTH = 16,
  parameter logic [ADDRESS_WIDTH-1:0] VECTOR_BASE   = 'h0100
) (
  input  logic                     clock,
  input  logic                     reset_n,
`ifdef EXCEPTION_MASK_EN
  input  logic                     mask_write,
  input  logic [5:0]               mask_data,
`endif
  input  logic [5:0]               exception_events,
  input  logic [ADDRESS_WIDTH-1:0] program_counter,
  input  logic                     pipeline_idle,
  input  logic                     vector_ack,
  input  logic                     return_from_trap,
  output logic                     pipeline_stall,
  output logic                     pipeline_flush,
  output logic                     vector_valid,
  output logic [ADDRESS_WIDTH-1:0] vector_address,
  output logic [2:0]               cause,
  output logic [ADDRESS_WIDTH-1:0] saved_pc,
  output logic                     trap_mode,
  output logic [5:0]               pending
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FLUSH,
    ST_VECTOR,
    ST_HANDLER
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] mask_eff;
  logic [5:0] eligible;
  logic       win_vld;
  logic [2:0] win_idx;
  logic       take;
  logic       swap;
  logic [5:0] clr_bits;
  logic [5:0] set_bits;
  logic [5:0] pending_nxt;

`ifdef EXCEPTION_MASK_EN
  logic [5:0] mask_q;

  // memory_corruption stays enabled whatever software writes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= 6'b111111;
    end else if (mask_write) begin
      mask_q <= mask_data | 6'b100000;
    end
  end

  assign mask_eff = mask_q;
`else
  assign mask_eff = 6'b111111;
`endif

  assign eligible = (pending | exception_events) & mask_eff;

  always_comb begin
    win_vld = 1'b0;
    win_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (eligible[i]) begin
        win_vld = 1'b1;
        win_idx = 3'(i);
      end
    end
  end

  assign take     = (state == ST_IDLE) && win_vld;
  assign swap     = (state == ST_DRAIN) && win_vld && (win_idx > cause);
  assign clr_bits = (take || swap) ? (6'(1) << win_idx) : 6'b0;
  assign set_bits = swap ? (6'(1) << cause) : 6'b0;

  // A fresh pulse on a bit that was already pending survives the clear;
  // a pulse that is itself being serviced is consumed.
  assign pending_nxt = (pending & ~clr_bits)
                     | (exception_events & ~(clr_bits & ~pending))
                     | set_bits;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (win_vld)          state_nxt = ST_DRAIN;
      ST_DRAIN:   if (pipeline_idle)    state_nxt = ST_FLUSH;
      ST_FLUSH:                         state_nxt = ST_VECTOR;
      ST_VECTOR:  if (vector_ack)       state_nxt = ST_HANDLER;
      ST_HANDLER: if (return_from_trap) state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pipeline_stall = 1'b0;
    pipeline_flush = 1'b0;
    vector_valid   = 1'b0;
    trap_mode      = 1'b0;
    case (state)
      ST_DRAIN:   pipeline_stall = 1'b1;
      ST_FLUSH: begin
        pipeline_stall = 1'b1;
        pipeline_flush = 1'b1;
      end
      ST_VECTOR: begin
        pipeline_stall = 1'b1;
        vector_valid   = 1'b1;
      end
      ST_HANDLER: trap_mode = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= 6'b0;
      cause    <= 3'd0;
      saved_pc <= '0;
    end else begin
      pending <= pending_nxt;
      if (take || swap) begin
        cause <= win_idx;
      end
      if (take) begin
        saved_pc <= program_counter;
      end
    end
  end

  assign vector_address = VECTOR_BASE + {{(ADDRESS_WIDTH-5){1'b0}}, cause, 2'b00};

endmodule

// File: tb/tb_exception_controller.sv
// Directed table-driven bench for exception_controller plus async-reset sequence.
module tb_exception_controller;

  logic        clock;
  logic        reset_n;
  logic [5:0]  exception_events;
  logic [15:0] program_counter;
  logic        pipeline_idle;
  logic        vector_ack;
  logic        return_from_trap;
  logic        pipeline_stall;
  logic        pipeline_flush;
  logic        vector_valid;
  logic [15:0] vector_address;
  logic [2:0]  cause;
  logic [15:0] saved_pc;
  logic        trap_mode;
  logic [5:0]  pending;
`ifdef EXCEPTION_MASK_EN
  logic        mask_write;
  logic [5:0]  mask_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  exception_controller #(.ADDRESS_WIDTH(16), .VECTOR_BASE(16'h0100)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
`ifdef EXCEPTION_MASK_EN
    .mask_write       (mask_write),
    .mask_data        (mask_data),
`endif
    .exception_events (exception_events),
    .program_counter  (program_counter),
    .pipeline_idle    (pipeline_idle),
    .vector_ack       (vector_ack),
    .return_from_trap (return_from_trap),
    .pipeline_stall   (pipeline_stall),
    .pipeline_flush   (pipeline_flush),
    .vector_valid     (vector_valid),
    .vector_address   (vector_address),
    .cause            (cause),
    .saved_pc         (saved_pc),
    .trap_mode        (trap_mode),
    .pending          (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  ev;
    logic [15:0] pc;
    logic        idl;
    logic        ack;
    logic        rft;
    logic        mw;
    logic [5:0]  md;
    logic        stall;
    logic        flush;
    logic        vv;
    logic [15:0] va;
    logic [2:0]  cause;
    logic        trap;
    logic [5:0]  pend;
    logic [15:0] spc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [5:0] ev, input logic [15:0] pc,
                             input logic idl, input logic ack, input logic rft,
                             input logic mw, input logic [5:0] md,
                             input logic stall, input logic flush, input logic vv,
                             input logic [15:0] va, input logic [2:0] cs,
                             input logic trap, input logic [5:0] pend,
                             input logic [15:0] spc);
    vec_t r;
    r.ev = ev; r.pc = pc; r.idl = idl; r.ack = ack; r.rft = rft;
    r.mw = mw; r.md = md; r.stall = stall; r.flush = flush; r.vv = vv;
    r.va = va; r.cause = cs; r.trap = trap; r.pend = pend; r.spc = spc;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t r);
    check({tag, " stall"},    32'(pipeline_stall), 32'(r.stall));
    check({tag, " flush"},    32'(pipeline_flush), 32'(r.flush));
    check({tag, " vvalid"},   32'(vector_valid),   32'(r.vv));
    check({tag, " vaddr"},    32'(vector_address), 32'(r.va));
    check({tag, " cause"},    32'(cause),          32'(r.cause));
    check({tag, " trap"},     32'(trap_mode),      32'(r.trap));
    check({tag, " pending"},  32'(pending),        32'(r.pend));
    check({tag, " saved_pc"}, 32'(saved_pc),       32'(r.spc));
  endtask

  initial begin
    reset_n          = 1'b0;
    exception_events = 6'b0;
    program_counter  = 16'h0;
    pipeline_idle    = 1'b0;
    vector_ack       = 1'b0;
    return_from_trap = 1'b0;
`ifdef EXCEPTION_MASK_EN
    mask_write       = 1'b0;
    mask_data        = 6'b0;
`endif

    // single bit3 trap, latency 1/2/3/4
    tbl.push_back(v(6'h08, 16'h0040, 1, 1, 0, 0, 6'h00, 1, 0, 0, 16'h010C, 3'd3, 0, 6'h00, 16'h0040));
    tbl.push_back(v(6'h00, 16'h0040, 1, 1, 0, 0, 6'h00, 1, 1, 0, 16'h010C, 3'd3, 0, 6'h00, 16'h0040));
    tbl.push_back(v(6'h00, 16'h0040, 1, 1, 0, 0, 6'h00, 1, 0, 1, 16'h010C, 3'd3, 0, 6'h00, 16'h0040));
    tbl.push_back(v(6'h00, 16'h0040, 1, 1, 0, 0, 6'h00, 0, 0, 0, 16'h010C, 3'd3, 1, 6'h00, 16'h0040));
    tbl.push_back(v(6'h00, 16'h0040, 1, 1, 1, 0, 6'h00, 0, 0, 0, 16'h010C, 3'd3, 0, 6'h00, 16'h0040));
    // bits 4 and 1 together: 4 first, 1 after one idle cycle
    tbl.push_back(v(6'h12, 16'h0080, 1, 1, 0, 0, 6'h00, 1, 0, 0, 16'h0110, 3'd4, 0, 6'h02, 16'h0080));
    tbl.push_back(v(6'h00, 16'h0080, 1, 1, 0, 0, 6'h00, 1, 1, 0, 16'h0110, 3'd4, 0, 6'h02, 16'h0080));
    tbl.push_back(v(6'h00, 16'h0080, 1, 1, 0, 0, 6'h00, 1, 0, 1, 16'h0110, 3'd4, 0, 6'h02, 16'h0080));
    tbl.push_back(v(6'h00, 16'h0080, 1, 1, 0, 0, 6'h00, 0, 0, 0, 16'h0110, 3'd4, 1, 6'h02, 16'h0080));
    tbl.push_back(v(6'h00, 16'h0080, 1, 1, 1, 0, 6'h00, 0, 0, 0, 16'h0110, 3'd4, 0, 6'h02, 16'h0080));
    tbl.push_back(v(6'h00, 16'h0090, 1, 1, 0, 0, 6'h00, 1, 0, 0, 16'h0104, 3'd1, 0, 6'h00, 16'h0090));
    tbl.push_back(v(6'h00, 16'h0090, 1, 1, 0, 0, 6'h00, 1, 1, 0, 16'h0104, 3'd1, 0, 6'h00, 16'h0090));
    tbl.push_back(v(6'h00, 16'h0090, 1, 1, 0, 0, 6'h00, 1, 0, 1, 16'h0104, 3'd1, 0, 6'h00, 16'h0090));
    tbl.push_back(v(6'h00, 16'h0090, 1, 1, 0, 0, 6'h00, 0, 0, 0, 16'h0104, 3'd1, 1, 6'h00, 16'h0090));
    tbl.push_back(v(6'h00, 16'h0090, 1, 1, 1, 0, 6'h00, 0, 0, 0, 16'h0104, 3'd1, 0, 6'h00, 16'h0090));
    // bit0 with long drain, bit5 preempts on drain cycle 2
    tbl.push_back(v(6'h01, 16'h0020, 0, 1, 0, 0, 6'h00, 1, 0, 0, 16'h0100, 3'd0, 0, 6'h00, 16'h0020));
    tbl.push_back(v(6'h00, 16'h0020, 0, 1, 0, 0, 6'h00, 1, 0, 0, 16'h0100, 3'd0, 0, 6'h00, 16'h0020));
    tbl.push_back(v(6'h20, 16'h0033, 0, 1, 0, 0, 6'h00, 1, 0, 0, 16'h0114, 3'd5, 0, 6'h01, 16'h0020));
    tbl.push_back(v(6'h00, 16'h0033, 0, 1, 0, 0, 6'h00, 1, 0, 0, 16'h0114, 3'd5, 0, 6'h01, 16'h0020));
    tbl.push_back(v(6'h00, 16'h0033, 0, 1, 0, 0, 6'h00, 1, 0, 0, 16'h0114, 3'd5, 0, 6'h01, 16'h0020));
    tbl.push_back(v(6'h00, 16'h0033, 1, 1, 0, 0, 6'h00, 1, 1, 0, 16'h0114, 3'd5, 0, 6'h01, 16'h0020));
    tbl.push_back(v(6'h00, 16'h0033, 1, 1, 0, 0, 6'h00, 1, 0, 1, 16'h0114, 3'd5, 0, 6'h01, 16'h0020));
    tbl.push_back(v(6'h00, 16'h0033, 1, 1, 0, 0, 6'h00, 0, 0, 0, 16'h0114, 3'd5, 1, 6'h01, 16'h0020));
    tbl.push_back(v(6'h00, 16'h0033, 1, 1, 1, 0, 6'h00, 0, 0, 0, 16'h0114, 3'd5, 0, 6'h01, 16'h0020));
    // re-entry for bit0 with vector_ack withheld three cycles
    tbl.push_back(v(6'h00, 16'h0050, 1, 0, 0, 0, 6'h00, 1, 0, 0, 16'h0100, 3'd0, 0, 6'h00, 16'h0050));
    tbl.push_back(v(6'h00, 16'h0050, 1, 0, 0, 0, 6'h00, 1, 1, 0, 16'h0100, 3'd0, 0, 6'h00, 16'h0050));
    tbl.push_back(v(6'h00, 16'h0050, 1, 0, 0, 0, 6'h00, 1, 0, 1, 16'h0100, 3'd0, 0, 6'h00, 16'h0050));
    tbl.push_back(v(6'h00, 16'h0050, 1, 0, 0, 0, 6'h00, 1, 0, 1, 16'h0100, 3'd0, 0, 6'h00, 16'h0050));
    tbl.push_back(v(6'h00, 16'h0050, 1, 0, 0, 0, 6'h00, 1, 0, 1, 16'h0100, 3'd0, 0, 6'h00, 16'h0050));
    tbl.push_back(v(6'h00, 16'h0050, 1, 1, 0, 0, 6'h00, 0, 0, 0, 16'h0100, 3'd0, 1, 6'h00, 16'h0050));
    tbl.push_back(v(6'h00, 16'h0050, 1, 1, 1, 0, 6'h00, 0, 0, 0, 16'h0100, 3'd0, 0, 6'h00, 16'h0050));
    // return in IDLE is ignored
    tbl.push_back(v(6'h00, 16'h0050, 1, 1, 1, 0, 6'h00, 0, 0, 0, 16'h0100, 3'd0, 0, 6'h00, 16'h0050));
`ifdef EXCEPTION_MASK_EN
    tbl.push_back(v(6'h00, 16'h0060, 1, 1, 0, 1, 6'h00, 0, 0, 0, 16'h0100, 3'd0, 0, 6'h00, 16'h0050));
    tbl.push_back(v(6'h04, 16'h0060, 1, 1, 0, 0, 6'h00, 0, 0, 0, 16'h0100, 3'd0, 0, 6'h04, 16'h0050));
    tbl.push_back(v(6'h20, 16'h0060, 1, 1, 0, 0, 6'h00, 1, 0, 0, 16'h0114, 3'd5, 0, 6'h04, 16'h0060));
    tbl.push_back(v(6'h00, 16'h0060, 1, 1, 0, 0, 6'h00, 1, 1, 0, 16'h0114, 3'd5, 0, 6'h04, 16'h0060));
    tbl.push_back(v(6'h00, 16'h0060, 1, 1, 0, 0, 6'h00, 1, 0, 1, 16'h0114, 3'd5, 0, 6'h04, 16'h0060));
    tbl.push_back(v(6'h00, 16'h0060, 1, 1, 0, 0, 6'h00, 0, 0, 0, 16'h0114, 3'd5, 1, 6'h04, 16'h0060));
    tbl.push_back(v(6'h00, 16'h0060, 1, 1, 1, 0, 6'h00, 0, 0, 0, 16'h0114, 3'd5, 0, 6'h04, 16'h0060));
    tbl.push_back(v(6'h00, 16'h0060, 1, 1, 0, 0, 6'h00, 0, 0, 0, 16'h0114, 3'd5, 0, 6'h04, 16'h0060));
    tbl.push_back(v(6'h00, 16'h0060, 1, 1, 0, 1, 6'h04, 0, 0, 0, 16'h0114, 3'd5, 0, 6'h04, 16'h0060));
    tbl.push_back(v(6'h00, 16'h0070, 1, 1, 0, 0, 6'h00, 1, 0, 0, 16'h0108, 3'd2, 0, 6'h00, 16'h0070));
    tbl.push_back(v(6'h00, 16'h0070, 1, 1, 0, 0, 6'h00, 1, 1, 0, 16'h0108, 3'd2, 0, 6'h00, 16'h0070));
    tbl.push_back(v(6'h00, 16'h0070, 1, 1, 0, 0, 6'h00, 1, 0, 1, 16'h0108, 3'd2, 0, 6'h00, 16'h0070));
    tbl.push_back(v(6'h00, 16'h0070, 1, 1, 0, 0, 6'h00, 0, 0, 0, 16'h0108, 3'd2, 1, 6'h00, 16'h0070));
    tbl.push_back(v(6'h00, 16'h0070, 1, 1, 1, 0, 6'h00, 0, 0, 0, 16'h0108, 3'd2, 0, 6'h00, 16'h0070));
`endif

    #12;
    check_outputs("reset", v(6'h00, 16'h0000, 0, 0, 0, 0, 6'h00, 0, 0, 0, 16'h0100, 3'd0, 0, 6'h00, 16'h0000));
    @(posedge clock);
    #1 reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      exception_events = tbl[i].ev;
      program_counter  = tbl[i].pc;
      pipeline_idle    = tbl[i].idl;
      vector_ack       = tbl[i].ack;
      return_from_trap = tbl[i].rft;
`ifdef EXCEPTION_MASK_EN
      mask_write       = tbl[i].mw;
      mask_data        = tbl[i].md;
`endif
      @(posedge clock);
      #1;
      check_outputs($sformatf("row%0d", i), tbl[i]);
    end

`ifdef EXCEPTION_MASK_EN
    mask_write = 1'b0;
    mask_data  = 6'b0;
`endif
    return_from_trap = 1'b0;

    // async reset while presenting a vector
    exception_events = 6'h10;
    program_counter  = 16'h0AA0;
    pipeline_idle    = 1'b1;
    vector_ack       = 1'b0;
    @(posedge clock);
    #1 exception_events = 6'h04;
    @(posedge clock);
    #1 exception_events = 6'h00;
    @(posedge clock);
    #1;
    check("pre-reset vvalid",  32'(vector_valid), 32'd1);
    check("pre-reset pending", 32'(pending),      32'h04);
    check("pre-reset cause",   32'(cause),        32'd4);
    #2 reset_n = 1'b0;
    #1;
    check_outputs("async reset", v(6'h00, 16'h0000, 0, 0, 0, 0, 6'h00, 0, 0, 0, 16'h0100, 3'd0, 0, 6'h00, 16'h0000));
    @(posedge clock);
    #1 reset_n = 1'b1;
    return_from_trap = 1'b1;
    vector_ack       = 1'b1;
    @(posedge clock);
    #1;
    return_from_trap = 1'b0;
    check_outputs("rft in idle", v(6'h00, 16'h0000, 0, 0, 0, 0, 6'h00, 0, 0, 0, 16'h0100, 3'd0, 0, 6'h00, 16'h0000));
    @(posedge clock);
    #1;
    check("idle stays stall", 32'(pipeline_stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
